// File: rtl/matmul_engine.sv
// NxN unsigned matrix-multiply engine: streams in A then B, computes C = A*B on one MAC, streams C out.
// Build option: define MATMUL_SAT_EN for saturating result formatting (default is wrap-around truncation).
module matmul_engine #(
  parameter int N     = 3,
  parameter int DW    = 8,
  parameter int ACC_W = 2*DW + $clog2(N) + 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_valid,
  input  logic [DW-1:0] i_data,
  output logic          o_in_ready,
  output logic          o_valid,
  output logic [DW-1:0] o_data,
  input  logic          i_out_ready,
  output logic          o_busy,
  output logic          o_done
);

  localparam int NN    = N * N;
  localparam int IDX_W = $clog2(NN);
  localparam int RC_W  = $clog2(N);
  localparam int K_W   = $clog2(N + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NN - 1);
  localparam logic [RC_W-1:0]  RC_LAST  = RC_W'(N - 1);
  localparam logic [K_W-1:0]   K_WB     = K_W'(N);
`ifdef MATMUL_SAT_EN
  localparam int FMT_W = ACC_W;
`else
  localparam int FMT_W = DW;
`endif

  typedef enum logic [1:0] {LOAD_A, LOAD_B, COMPUTE, SEND} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [RC_W-1:0]    row_q, row_d, col_q, col_d;
  logic [K_W-1:0]     k_q, k_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               valid_q, valid_d;
  logic [DW-1:0]      data_q, data_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [DW-1:0]      a_mem [NN];
  logic [DW-1:0]      b_mem [NN];
  logic [DW-1:0]      c_mem [NN];

  logic               in_rdy, in_xfer, out_xfer;
  logic               a_we, b_we, c_we;
  logic [RC_W-1:0]    k_rd;
  logic [IDX_W-1:0]   a_addr, b_addr, c_addr;
  logic [2*DW-1:0]    prod;

  // Saturating build clamps to the largest element value; default build keeps the low DW bits.
  function automatic logic [DW-1:0] fmt(input logic [FMT_W-1:0] a);
`ifdef MATMUL_SAT_EN
    if (a > {{(ACC_W-DW){1'b0}}, {DW{1'b1}}}) return {DW{1'b1}};
    return a[DW-1:0];
`else
    return a;
`endif
  endfunction

  assign in_rdy   = (state_q == LOAD_A) || (state_q == LOAD_B);
  assign in_xfer  = i_valid && in_rdy;
  assign out_xfer = valid_q && i_out_ready;

  // On the writeback cycle k_q == N, which is not a valid operand index.
  assign k_rd   = (k_q < K_WB) ? RC_W'(k_q) : '0;
  assign a_addr = IDX_W'(int'(row_q) * N + int'(k_rd));
  assign b_addr = IDX_W'(int'(k_rd) * N + int'(col_q));
  assign c_addr = IDX_W'(int'(row_q) * N + int'(col_q));
  assign prod   = {{DW{1'b0}}, a_mem[a_addr]} * {{DW{1'b0}}, b_mem[b_addr]};

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    row_d   = row_q;
    col_d   = col_q;
    k_d     = k_q;
    acc_d   = acc_q;
    valid_d = valid_q;
    data_d  = data_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    a_we    = 1'b0;
    b_we    = 1'b0;
    c_we    = 1'b0;
    case (state_q)
      LOAD_A: begin
        if (in_xfer) begin
          a_we = 1'b1;
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = LOAD_B;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      LOAD_B: begin
        if (in_xfer) begin
          b_we = 1'b1;
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            row_d   = '0;
            col_d   = '0;
            k_d     = '0;
            busy_d  = 1'b1;
            state_d = COMPUTE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      COMPUTE: begin
        if (k_q != K_WB) begin
          acc_d = ((k_q == '0) ? '0 : acc_q) + ACC_W'(prod);
          k_d   = k_q + K_W'(1);
        end else begin
          c_we = 1'b1;
          k_d  = '0;
          if (col_q == RC_LAST) begin
            col_d = '0;
            if (row_q == RC_LAST) begin
              row_d   = '0;
              valid_d = 1'b1;
              data_d  = c_mem[0];
              state_d = SEND;
            end else begin
              row_d = row_q + RC_W'(1);
            end
          end else begin
            col_d = col_q + RC_W'(1);
          end
        end
      end
      SEND: begin
        if (out_xfer) begin
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = LOAD_A;
          end else begin
            idx_d  = idx_q + IDX_W'(1);
            data_d = c_mem[idx_q + IDX_W'(1)];
          end
        end
      end
      default: state_d = LOAD_A;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= LOAD_A;
      idx_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      k_q     <= '0;
      acc_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      row_q   <= row_d;
      col_q   <= col_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Matrix stores survive reset; a fresh load always rewrites every element before use.
  always_ff @(posedge i_clk) begin
    if (a_we && !i_rst) a_mem[idx_q] <= i_data;
    if (b_we && !i_rst) b_mem[idx_q] <= i_data;
    if (c_we && !i_rst) c_mem[c_addr] <= fmt(acc_q[FMT_W-1:0]);
  end

  assign o_in_ready = in_rdy;
  assign o_valid    = valid_q;
  assign o_data     = data_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;

endmodule

// File: tb/tb_matmul_engine.sv
// Bench for matmul_engine (N=3, DW=8): table of matrix pairs with expected C, scoreboard on the output stream.
module tb_matmul_engine;

  logic       clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_valid = 1'b0;
  logic [7:0] i_data = 8'd0;
  logic       o_in_ready;
  logic       o_valid;
  logic [7:0] o_data;
  logic       i_out_ready = 1'b0;
  logic       o_busy;
  logic       o_done;

  int total = 0;
  int bad   = 0;
  logic [7:0] sb[$];

  typedef struct packed {
    logic [71:0] a;
    logic [71:0] b;
    logic [71:0] c;
    int          hold_at;
    bit          keep_valid;
  } vec_t;

  vec_t tbl[6];

  matmul_engine #(.N(3), .DW(8)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .i_data(i_data),
    .o_in_ready(o_in_ready), .o_valid(o_valid), .o_data(o_data),
    .i_out_ready(i_out_ready), .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [71:0] rep9(input logic [7:0] x);
    return {9{x}};
  endfunction

  function automatic logic [71:0] seq9();
    logic [71:0] r;
    for (int e = 0; e < 9; e++) r[e*8 +: 8] = 8'(e + 1);
    return r;
  endfunction

  function automatic logic [71:0] ident();
    logic [71:0] r;
    for (int e = 0; e < 9; e++) r[e*8 +: 8] = (e % 4 == 0) ? 8'd1 : 8'd0;
    return r;
  endfunction

  function automatic logic [71:0] model(input logic [71:0] a, input logic [71:0] b);
    logic [71:0] r;
    int s;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        s = 0;
        for (int k = 0; k < 3; k++)
          s += int'(a[(i*3+k)*8 +: 8]) * int'(b[(k*3+j)*8 +: 8]);
`ifdef MATMUL_SAT_EN
        r[(i*3+j)*8 +: 8] = (s > 255) ? 8'hFF : 8'(s);
`else
        r[(i*3+j)*8 +: 8] = 8'(s);
`endif
      end
    return r;
  endfunction

  task automatic push_elem(input logic [7:0] d);
    int w = 0;
    @(negedge clk);
    i_valid = 1'b1;
    i_data  = d;
    while (!o_in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!o_in_ready) chk("in_ready_timeout", 32'(o_in_ready), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    int cyc;
    int w;
    for (int e = 0; e < 9; e++) push_elem(v.a[e*8 +: 8]);
    for (int e = 0; e < 9; e++) push_elem(v.b[e*8 +: 8]);
    for (int e = 0; e < 9; e++) sb.push_back(v.c[e*8 +: 8]);
    if (v.keep_valid) begin
      i_valid = 1'b1;
      i_data  = 8'hAA;
    end else begin
      i_valid = 1'b0;
    end
    chk("busy_after_load", 32'(o_busy), 32'd1);
    chk("in_ready_after_load", 32'(o_in_ready), 32'd0);
    cyc = 0;
    while (!o_valid && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("latency", 32'(cyc), 32'd36);
    for (int e = 0; e < 9; e++) begin
      if (e == v.hold_at) begin
        i_out_ready = 1'b0;
        for (int h = 0; h < 5; h++) begin
          @(negedge clk);
          chk("hold_valid", 32'(o_valid), 32'd1);
          chk("hold_data", 32'(o_data), 32'(sb[0]));
          @(posedge clk);
          #1;
        end
      end
      i_out_ready = 1'b1;
      @(negedge clk);
      w = 0;
      while (!o_valid && w < 50) begin
        @(negedge clk);
        w++;
      end
      chk("out_valid", 32'(o_valid), 32'd1);
      chk("out_data", 32'(o_data), 32'(sb.pop_front()));
      chk("done_early", 32'(o_done), 32'd0);
      @(posedge clk);
      #1;
    end
    i_out_ready = 1'b0;
    i_valid     = 1'b0;
    chk("done_pulse", 32'(o_done), 32'd1);
    chk("busy_end", 32'(o_busy), 32'd0);
    chk("valid_end", 32'(o_valid), 32'd0);
    chk("in_ready_end", 32'(o_in_ready), 32'd1);
    @(posedge clk);
    #1;
    chk("done_one_cycle", 32'(o_done), 32'd0);
  endtask

  initial begin
    logic [71:0] ra, rb;
    tbl[0] = '{a: ident(), b: seq9(), c: seq9(), hold_at: -1, keep_valid: 1'b0};
    tbl[1] = '{a: rep9(8'd2), b: rep9(8'd3), c: rep9(8'd18), hold_at: -1, keep_valid: 1'b0};
`ifdef MATMUL_SAT_EN
    tbl[2] = '{a: rep9(8'hFF), b: rep9(8'hFF), c: rep9(8'hFF), hold_at: -1, keep_valid: 1'b0};
`else
    tbl[2] = '{a: rep9(8'hFF), b: rep9(8'hFF), c: rep9(8'h03), hold_at: -1, keep_valid: 1'b0};
`endif
    tbl[3] = '{a: ident(), b: seq9(), c: seq9(), hold_at: 4, keep_valid: 1'b0};
    for (int e = 0; e < 9; e++) begin
      ra[e*8 +: 8] = 8'($urandom_range(0, 20));
      rb[e*8 +: 8] = 8'($urandom_range(0, 255));
    end
    tbl[4] = '{a: ra, b: rb, c: model(ra, rb), hold_at: 2, keep_valid: 1'b0};
    tbl[5] = '{a: seq9(), b: ident(), c: seq9(), hold_at: -1, keep_valid: 1'b1};

    repeat (2) @(posedge clk);
    #1;
    i_rst = 1'b0;
    chk("rst_in_ready", 32'(o_in_ready), 32'd1);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_data", 32'(o_data), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);

    for (int t = 0; t < 6; t++) run_vec(tbl[t]);

    // Abort a load part-way through B, then reload from scratch.
    for (int e = 0; e < 9; e++) push_elem(8'd7);
    for (int e = 0; e < 4; e++) push_elem(8'd9);
    i_valid = 1'b0;
    i_rst   = 1'b1;
    @(posedge clk);
    #1;
    i_rst = 1'b0;
    chk("abort_in_ready", 32'(o_in_ready), 32'd1);
    chk("abort_busy", 32'(o_busy), 32'd0);
    run_vec(tbl[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
